prbs31_check32b: RTL and testbench

Per-channel PRBS31 receive checker for the GBCR2 SEU test. It consumes the 32-bit parallel word recovered by one GTX receiver, which carries the bit-reversed PRBS31 stream produced by the transmit data source. It self-synchronizes to the sequence, then free-runs its own LFSR and counts bit and word errors, including injected errors. One instance is used per Rx/Tx channel.

---
 rtl/prbs31_check32b.sv | 221 ++++++++++++++++++++++
 tb/tb_prbs31_check32b.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs31_check32b.sv
// PRBS31 (x^31+x^28+1) receive checker for one GTX channel: self-synchronises, then free-runs and counts errors.
// Define PRBS31_CHK_BITCNT_EN to build the popcount and err_bit_cnt; otherwise err_bits is a 0/1 mismatch flag.
module prbs31_check32b #(
    parameter int LOCK_THRESHOLD   = 16,
    parameter int UNLOCK_THRESHOLD = 4,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rx_data,
    input  logic             rx_valid,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_flag,
    output logic [5:0]       err_bits,
    output logic [CNT_W-1:0] err_word_cnt,
    output logic [CNT_W-1:0] err_bit_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

    localparam int MATCH_W = $clog2(LOCK_THRESHOLD + 1);
    localparam int BAD_W   = $clog2(UNLOCK_THRESHOLD + 1);
    localparam int SUM_W   = ((CNT_W > 6) ? CNT_W : 6) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    state_t               state_q, state_d;
    logic                 in_valid_q, in_valid_d;
    logic [31:0]          in_data_q, in_data_d;
    logic                 seeded_q, seeded_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic [31:0]          exp_q, exp_d;
    logic                 err_flag_q, err_flag_d;
    logic [5:0]           err_bits_q, err_bits_d;
    logic                 word_inc_q, word_inc_d;
    logic                 err_inc_q, err_inc_d;
    logic [CNT_W-1:0]     err_word_cnt_q, err_word_cnt_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
`ifdef PRBS31_CHK_BITCNT_EN
    logic [CNT_W-1:0]     err_bit_cnt_q, err_bit_cnt_d;
`endif

    logic [31:0] rx_rev;
    logic [31:0] diff;
    logic        mismatch;
    logic [31:0] next_w;
    logic [5:0]  bits_now;

    // The next 32 serial bits from the last 31; s[63] is the first serial bit of w, s[31] the first predicted bit.
    function automatic logic [31:0] next_word(input logic [31:0] w);
        logic [63:0] s;
        s = {w, 32'h0};
        for (int i = 31; i >= 0; i--) begin
            s[i] = s[i+31] ^ s[i+28];
        end
        return s[31:0];
    endfunction

`ifdef PRBS31_CHK_BITCNT_EN
    function automatic logic [5:0] popcount32(input logic [31:0] x);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 6'(x[i]);
        end
        return n;
    endfunction
`endif

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [5:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > CNT_MAX) begin
            sat_add = '1;
        end else begin
            sat_add = s[CNT_W-1:0];
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= SEARCH;
            in_valid_q     <= 1'b0;
            in_data_q      <= '0;
            seeded_q       <= 1'b0;
            match_cnt_q    <= '0;
            bad_cnt_q      <= '0;
            exp_q          <= '0;
            err_flag_q     <= 1'b0;
            err_bits_q     <= '0;
            word_inc_q     <= 1'b0;
            err_inc_q      <= 1'b0;
            err_word_cnt_q <= '0;
            word_cnt_q     <= '0;
`ifdef PRBS31_CHK_BITCNT_EN
            err_bit_cnt_q  <= '0;
`endif
        end else begin
            state_q        <= state_d;
            in_valid_q     <= in_valid_d;
            in_data_q      <= in_data_d;
            seeded_q       <= seeded_d;
            match_cnt_q    <= match_cnt_d;
            bad_cnt_q      <= bad_cnt_d;
            exp_q          <= exp_d;
            err_flag_q     <= err_flag_d;
            err_bits_q     <= err_bits_d;
            word_inc_q     <= word_inc_d;
            err_inc_q      <= err_inc_d;
            err_word_cnt_q <= err_word_cnt_d;
            word_cnt_q     <= word_cnt_d;
`ifdef PRBS31_CHK_BITCNT_EN
            err_bit_cnt_q  <= err_bit_cnt_d;
`endif
        end
    end

    // exp_q is the received-word prediction while searching and the free-running LFSR once locked.
    always_comb begin
        state_d        = state_q;
        seeded_d       = seeded_q;
        match_cnt_d    = match_cnt_q;
        bad_cnt_d      = bad_cnt_q;
        exp_d          = exp_q;
        err_flag_d     = 1'b0;
        err_bits_d     = '0;
        word_inc_d     = 1'b0;
        err_inc_d      = 1'b0;
        err_word_cnt_d = err_word_cnt_q;
        word_cnt_d     = word_cnt_q;
`ifdef PRBS31_CHK_BITCNT_EN
        err_bit_cnt_d  = err_bit_cnt_q;
`endif

        rx_rev = '0;
        for (int i = 0; i < 32; i++) begin
            rx_rev[i] = rx_data[31-i];
        end
        in_valid_d = rx_valid;
        in_data_d  = rx_valid ? rx_rev : in_data_q;

        diff     = in_data_q ^ exp_q;
        mismatch = |diff;
`ifdef PRBS31_CHK_BITCNT_EN
        bits_now = popcount32(diff);
`else
        bits_now = {5'b0, mismatch};
`endif
        next_w = next_word((state_q == LOCKED) ? exp_q : in_data_q);

        if (in_valid_q) begin
            exp_d = next_w;
            case (state_q)
                SEARCH: begin
                    if (!seeded_q) begin
                        seeded_d = 1'b1;
                    end else begin
                        err_flag_d = mismatch;
                        err_bits_d = bits_now;
                        if (mismatch) begin
                            match_cnt_d = '0;
                        end else if (match_cnt_q == MATCH_W'(LOCK_THRESHOLD - 1)) begin
                            state_d     = LOCKED;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = match_cnt_q + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    err_flag_d = mismatch;
                    err_bits_d = bits_now;
                    word_inc_d = 1'b1;
                    err_inc_d  = mismatch;
                    if (!mismatch) begin
                        bad_cnt_d = '0;
                    end else if (bad_cnt_q == BAD_W'(UNLOCK_THRESHOLD - 1)) begin
                        state_d     = SEARCH;
                        bad_cnt_d   = '0;
                        seeded_d    = 1'b0;
                        match_cnt_d = '0;
                    end else begin
                        bad_cnt_d = bad_cnt_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end

        // Clear overrides whatever increment is sitting in the counter stage.
        if (clear_cnt) begin
            err_word_cnt_d = '0;
            word_cnt_d     = '0;
`ifdef PRBS31_CHK_BITCNT_EN
            err_bit_cnt_d  = '0;
`endif
        end else begin
            if (word_inc_q) word_cnt_d = sat_add(word_cnt_q, 6'd1);
            if (err_inc_q) err_word_cnt_d = sat_add(err_word_cnt_q, 6'd1);
`ifdef PRBS31_CHK_BITCNT_EN
            if (err_inc_q) err_bit_cnt_d = sat_add(err_bit_cnt_q, err_bits_q);
`endif
        end
    end

    always_comb begin
        locked       = (state_q == LOCKED);
        err_flag     = err_flag_q;
        err_bits     = err_bits_q;
        err_word_cnt = err_word_cnt_q;
        word_cnt     = word_cnt_q;
`ifdef PRBS31_CHK_BITCNT_EN
        err_bit_cnt  = err_bit_cnt_q;
`else
        err_bit_cnt  = '0;
`endif
    end

endmodule

// File: tb/tb_prbs31_check32b.sv
// Scoreboard bench for prbs31_check32b: a CNT_W=32 and a CNT_W=4 instance share one stimulus stream.
// Honours PRBS31_CHK_BITCNT_EN when choosing expected err_bits / err_bit_cnt values.
module tb_prbs31_check32b;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        clear_cnt = 1'b0;

    logic        locked, err_flag;
    logic [5:0]  err_bits;
    logic [31:0] err_word_cnt, err_bit_cnt, word_cnt;
    logic        locked4, err_flag4;
    logic [5:0]  err_bits4;
    logic [3:0]  err_word_cnt4, err_bit_cnt4, word_cnt4;

    prbs31_check32b #(.LOCK_THRESHOLD(16), .UNLOCK_THRESHOLD(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear_cnt(clear_cnt),
        .locked(locked), .err_flag(err_flag), .err_bits(err_bits),
        .err_word_cnt(err_word_cnt), .err_bit_cnt(err_bit_cnt), .word_cnt(word_cnt)
    );

    prbs31_check32b #(.LOCK_THRESHOLD(16), .UNLOCK_THRESHOLD(4), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .clear_cnt(clear_cnt),
        .locked(locked4), .err_flag(err_flag4), .err_bits(err_bits4),
        .err_word_cnt(err_word_cnt4), .err_bit_cnt(err_bit_cnt4), .word_cnt(word_cnt4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int due; logic lk; logic ef; logic [5:0] eb;} flagRec_t;
    typedef struct {int due; logic [31:0] ew; logic [31:0] eb; logic [31:0] wc;
                    logic [31:0] ew4; logic [31:0] eb4; logic [31:0] wc4;} cntRec_t;
    typedef struct {bit w; bit e; int b;} incRec_t;

    flagRec_t flagQ[$];
    cntRec_t  cntQ[$];

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [30:0] genHist;
    bit          genFirst;
    bit          mLocked, mSeeded;
    int          mMatch, mBad;
    logic [31:0] mEw, mEb, mWc, mEw4, mEb4, mWc4;
    incRec_t     incD1, incD2;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Bit-serial x^31+x^28+1 generator; first serial bit lands in w[31].
    task automatic genNext(output logic [31:0] w);
        logic b;
        if (genFirst) begin
            genFirst = 1'b0;
            w = 32'h7FFF_FFFF;
        end else begin
            w = '0;
            for (int i = 0; i < 32; i++) begin
                b = genHist[30] ^ genHist[27];
                w = {w[30:0], b};
                genHist = {genHist[29:0], b};
            end
        end
    endtask

    function automatic logic [31:0] satAdd(input logic [31:0] a, input int b, input int w);
        longint s, mx;
        mx = (64'd1 << w) - 1;
        s = longint'(a) + longint'(b);
        return (s > mx) ? mx[31:0] : s[31:0];
    endfunction

    function automatic int expBits(input logic [31:0] mask);
`ifdef PRBS31_CHK_BITCNT_EN
        return $countones(mask);
`else
        return (mask != 0) ? 1 : 0;
`endif
    endfunction

    task automatic checkDue();
        flagRec_t f;
        cntRec_t  c;
        while (flagQ.size() > 0 && flagQ[0].due <= cyc) begin
            f = flagQ.pop_front();
            checkOutput("locked", locked, f.lk);
            checkOutput("err_flag", err_flag, f.ef);
            checkOutput("err_bits", err_bits, f.eb);
            checkOutput("locked4", locked4, f.lk);
        end
        while (cntQ.size() > 0 && cntQ[0].due <= cyc) begin
            c = cntQ.pop_front();
            checkOutput("err_word_cnt", err_word_cnt, c.ew);
            checkOutput("err_bit_cnt", err_bit_cnt, c.eb);
            checkOutput("word_cnt", word_cnt, c.wc);
            checkOutput("err_word_cnt4", 32'(err_word_cnt4), c.ew4);
            checkOutput("err_bit_cnt4", 32'(err_bit_cnt4), c.eb4);
            checkOutput("word_cnt4", 32'(word_cnt4), c.wc4);
        end
    endtask

    // One clock of stimulus: check what is due, drive the inputs, push expectations.
    task automatic applyStimulus(input bit v, input logic [31:0] mask, input bit clr);
        logic [31:0] p;
        flagRec_t    f;
        cntRec_t     c;
        incRec_t     inc;
        int          nb;
        bit          mis;
        @(negedge clk);
        checkDue();
        if (v) begin
            genNext(p);
            p = p ^ mask;
            rx_data = {<<{p}};
        end else begin
            rx_data = $urandom;
        end
        rx_valid  = v;
        clear_cnt = clr;

        inc = '{w: 1'b0, e: 1'b0, b: 0};
        f.due = cyc + 2; f.ef = 1'b0; f.eb = '0;
        if (v) begin
            nb  = expBits(mask);
            mis = (mask != 0);
            if (!mLocked) begin
                if (!mSeeded) begin
                    mSeeded = 1'b1;
                end else begin
                    f.ef = mis; f.eb = 6'(nb);
                    if (mis) mMatch = 0;
                    else begin
                        mMatch++;
                        if (mMatch == 16) begin mLocked = 1'b1; mMatch = 0; end
                    end
                end
            end else begin
                f.ef = mis; f.eb = 6'(nb);
                inc.w = 1'b1;
                inc.e = mis;
`ifdef PRBS31_CHK_BITCNT_EN
                inc.b = nb;
`endif
                if (mis) begin
                    mBad++;
                    if (mBad == 4) begin mLocked = 1'b0; mBad = 0; mSeeded = 1'b0; mMatch = 0; end
                end else mBad = 0;
            end
        end
        f.lk = mLocked;
        flagQ.push_back(f);

        if (clr) begin
            mEw = 0; mEb = 0; mWc = 0; mEw4 = 0; mEb4 = 0; mWc4 = 0;
        end else begin
            mWc  = satAdd(mWc,  incD2.w ? 1 : 0, 32);
            mEw  = satAdd(mEw,  incD2.e ? 1 : 0, 32);
            mEb  = satAdd(mEb,  incD2.e ? incD2.b : 0, 32);
            mWc4 = satAdd(mWc4, incD2.w ? 1 : 0, 4);
            mEw4 = satAdd(mEw4, incD2.e ? 1 : 0, 4);
            mEb4 = satAdd(mEb4, incD2.e ? incD2.b : 0, 4);
        end
        c = '{due: cyc + 1, ew: mEw, eb: mEb, wc: mWc, ew4: mEw4, eb4: mEb4, wc4: mWc4};
        cntQ.push_back(c);
        incD2 = incD1;
        incD1 = inc;
    endtask

    task automatic checkResetState();
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_err_flag", err_flag, 0);
        checkOutput("rst_err_bits", err_bits, 0);
        checkOutput("rst_err_word_cnt", err_word_cnt, 0);
        checkOutput("rst_err_bit_cnt", err_bit_cnt, 0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        checkOutput("rst_locked4", locked4, 0);
        checkOutput("rst_word_cnt4", 32'(word_cnt4), 0);
    endtask

    // Reset with rx_valid and clear_cnt deliberately high; the generator restarts from its seed.
    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1; rx_valid = 1'b1; clear_cnt = 1'b1; rx_data = $urandom;
        @(negedge clk);
        reset = 1'b0; rx_valid = 1'b0; clear_cnt = 1'b0;
        checkResetState();
        flagQ.delete();
        cntQ.delete();
        genHist = 31'h7FFF_FFFF; genFirst = 1'b1;
        mLocked = 1'b0; mSeeded = 1'b0; mMatch = 0; mBad = 0;
        mEw = 0; mEb = 0; mWc = 0; mEw4 = 0; mEb4 = 0; mWc4 = 0;
        incD1 = '{w: 1'b0, e: 1'b0, b: 0};
        incD2 = '{w: 1'b0, e: 1'b0, b: 0};
    endtask

    initial begin
        applyReset();

        // Clean stream: lock after the 17th word
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("lockedAfterClean", locked, 1);

        // Single flipped bit while locked
        applyStimulus(1'b1, 32'h0000_0020, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("bit5_err_word_cnt", err_word_cnt, 1);
`ifdef PRBS31_CHK_BITCNT_EN
        checkOutput("bit5_err_bit_cnt", err_bit_cnt, 1);
`else
        checkOutput("bit5_err_bit_cnt", err_bit_cnt, 0);
`endif
        checkOutput("bit5_locked", locked, 1);

        // Four inverted words force unlock, then relock on clean data
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("unlocked", locked, 0);
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("relocked", locked, 1);
        checkOutput("inv_err_word_cnt", err_word_cnt, 5);
`ifdef PRBS31_CHK_BITCNT_EN
        checkOutput("inv_err_bit_cnt", err_bit_cnt, 129);
`endif

        // clear_cnt coinciding with an errored word's counter update
        applyStimulus(1'b1, 32'h0000_1000, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("clr_err_word_cnt", err_word_cnt, 0);
        checkOutput("clr_word_cnt", word_cnt, 0);
        checkOutput("clr_locked", locked, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0, 1'b0);

        // rx_valid toggling: 17 valid words over 34 cycles
        applyReset();
        for (int i = 0; i < 34; i++) applyStimulus((i % 2) == 0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);
        checkOutput("toggle_locked", locked, 1);
        checkOutput("toggle_word_cnt", word_cnt, 0);
        checkOutput("toggle_err_word_cnt", err_word_cnt, 0);

        // Alternating error/clean words saturate the 4-bit counter without unlocking
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'h1 << $urandom_range(31, 0), 1'b0);
            applyStimulus(1'b1, 32'h0, 1'b0);
        end
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0, 1'b0);
        checkOutput("sat_err_word_cnt4", 32'(err_word_cnt4), 15);
        checkOutput("sat_err_word_cnt", err_word_cnt, 20);
        checkOutput("sat_locked", locked, 1);

        // Reset while locked
        applyReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
